ad7606x_pif_responder: RTL and testbench
========================================

Name: ad7606x_pif_responder

Overview:
Synthesizable device-side model of the AD7606x parallel interface, the ADC end of the link driven by the axi_ad7606x host controller. Responds to CNVST_N with a BUSY pulse of programmable length. Serves one 16-bit word per RD_N strobe, with FRSTDATA on channel 0 and an optional trailing status word. Accepts host register writes over WR_N. Used in simulation harnesses and as an FPGA loopback target.

Parameters:
DEV_CONFIG, 3, device variant; 0/1 = 8-channel part, 2/3 = 16-channel part
BUSY_CYCLES, 10, sys_clk cycles BUSY stays high per conversion (minimum 2)
STATUS_WORD, 16'h5A00, upper-byte tag OR'd into the status word

Ports:
sys_clk  in  1  single clock; all inputs are synchronous to it
rst  in  1  synchronous, active-high reset
adc_config_mode  in  2  0/2 = data only; 1/3 = data plus status; on DEV_CONFIG 0/1, modes 2/3 double channel reads to 16
cnvst_n  in  1  conversion start, active low
cs_n  in  1  chip select, active low
rd_n  in  1  read strobe, active low
wr_n  in  1  write strobe, active low
db_i  in  16  bus value driven by host during writes
busy  out  1  conversion in progress
first_data  out  1  high while word 0 is driven
db_o  out  16  read data
db_t  out  1  tristate; 1 = released
reg_wr_valid  out  1  one-cycle pulse on a completed write
reg_wr_data  out  16  captured write word
overrun  out  1  one-cycle pulse on an illegal conversion start

Behaviour:
- Reset values: busy=0, first_data=0, db_o=0, db_t=1, reg_wr_valid=0, reg_wr_data=0, overrun=0; state IDLE; ptr=0; conv_cnt=0.
- Edge detection: cnvst_n, rd_n and wr_n are each registered once (prev value reset to 1). A fall is prev=1 & cur=0; a rise is prev=0 & cur=1. Responses appear on the sys_clk edge after detection.
- num_words: 8 for DEV_CONFIG 0/1 with mode 0, else 16. Add 1 when mode[0]=1 (giving 8/9/16/17). adc_config_mode is sampled at conversion end.
- Word k < num_ch is {k[3:0], conv_cnt[11:0]}. The status word is STATUS_WORD | num_ch (16-channel part: 16'h5A10).
- State IDLE: a cnvst_n fall moves to CONV, sets busy=1, loads the busy counter with BUSY_CYCLES-1.
- State CONV: the counter decrements each cycle. At 0: busy=0, conv_cnt++ (12-bit wrap 4095→0), ptr=0, state READY. A cnvst_n fall in CONV pulses overrun and is otherwise ignored; busy is not extended.
- State READY: an rd_n fall with cs_n=0 drives word[ptr], sets db_t=0, and sets first_data=(ptr==0). An rd_n rise with cs_n=0 releases the bus (db_t=1, first_data=0) and increments ptr. When ptr reaches num_words, return to IDLE.
- A cnvst_n fall in READY pulses overrun, aborts the readout (ptr=0, db_t=1), and enters CONV. This wins over a simultaneous rd_n edge.
- rd_n edges with cs_n=1 are ignored.
- rd_n falls in IDLE or CONV drive db_o=16'h0000 with db_t=0, do not move ptr, and release on the rise.
- cs_n rising at any time forces db_t=1 and first_data=0 and keeps ptr.
- Write: a wr_n rise with cs_n=0 and db_t=1 captures db_i into reg_wr_data and pulses reg_wr_valid. A write is legal in any state and does not change state.
- rst in any state forces reset values next edge; a conversion or readout in progress is discarded.

Decomposition:
- Package ad7606x_pif_pkg holds:
  - enum state_t {IDLE, CONV, READY}
  - constant STATUS_TAG
  - function num_words(dev_config, mode) returning 5 bits, shared with the bench scoreboard
- One sub-module, ad7606x_edge_det: single-bit register plus fall/rise outputs, reset to 1. Instantiated three times.

Test Plan:
1. DEV_CONFIG=3, mode 0: cnvst_n low pulse → busy high exactly 10 cycles. Then 16 cs_n/rd_n strobes → db_o 16'h0001, 16'h1001 … 16'hF001. first_data only on the first word. State returns to IDLE.
2. Mode 1: conversion, then 17 reads → 17th word 16'h5A10. A second conversion returns words 16'h0002….
3. DEV_CONFIG=0, mode 0 → 8 words, last 16'h7001. Mode 1 → 9 words, last 16'h5A08.
4. cnvst_n fall at busy cycle 4 → overrun pulses once; busy falls on schedule. cnvst_n fall after 3 reads → overrun, busy reasserts, next read returns word 0.
5. cs_n=0, db_i=16'h1234, wr_n low 2 cycles then high → reg_wr_valid one cycle, reg_wr_data=16'h1234. rd_n strobes with cs_n=1 → db_t stays 1, ptr unchanged.
6. rst asserted mid-readout (ptr=5) → next edge all outputs at reset values. A fresh conversion yields conv_cnt=1 data.

Source files
------------

// File: rtl/ad7606x_pif_pkg.sv
// Shared types and helpers for the AD7606x parallel-interface device model.
// Both the responder and its testbench scoreboard use num_words.
package ad7606x_pif_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        READY = 2'd2
    } state_t;

    localparam logic [15:0] STATUS_TAG = 16'h5A00;

    // 8-channel parts only read 8 words unless mode[1] doubles them; mode[0] adds the status word.
    function automatic logic [4:0] num_words(input int dev_config, input logic [1:0] mode);
        logic [4:0] n;
        n = ((dev_config < 2) && !mode[1]) ? 5'd8 : 5'd16;
        return n + {4'd0, mode[0]};
    endfunction

endpackage

// File: rtl/ad7606x_edge_det.sv
// One-flop edge detector for an active-low strobe; the history resets to the idle (high) level.
module ad7606x_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic fall,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk) begin
        if (rst) prev <= 1'b1;
        else     prev <= din;
    end

    assign fall = prev & ~din;
    assign rise = ~prev & din;

endmodule

// File: rtl/ad7606x_pif_responder.sv
// Device end of the AD7606x parallel interface: BUSY after CNVST_N, one word per RD_N strobe,
// optional trailing status word, and host register writes captured on the WR_N rise.
module ad7606x_pif_responder
    import ad7606x_pif_pkg::*;
#(
    parameter int          DEV_CONFIG  = 3,
    parameter int          BUSY_CYCLES = 10,
    parameter logic [15:0] STATUS_WORD = STATUS_TAG
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic [1:0]  adc_config_mode,
    input  logic        cnvst_n,
    input  logic        cs_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic [15:0] db_i,
    output logic        busy,
    output logic        first_data,
    output logic [15:0] db_o,
    output logic        db_t,
    output logic        reg_wr_valid,
    output logic [15:0] reg_wr_data,
    output logic        overrun
);

    localparam logic [15:0] BUSY_LOAD = 16'(BUSY_CYCLES - 1);

    state_t      state, state_next;
    logic [15:0] busy_cnt;
    logic [11:0] conv_cnt;
    logic [4:0]  ptr;
    logic [4:0]  num_w;
    logic [4:0]  num_ch;

    logic cnv_fall, cnv_rise_unused;
    logic rd_fall, rd_rise;
    logic wr_fall_unused, wr_rise;

    logic start_conv, conv_done, ovr_next;
    logic rd_take, rd_done, last_word;
    logic [15:0] word;

    ad7606x_edge_det u_cnv (.clk(sys_clk), .rst(rst), .din(cnvst_n), .fall(cnv_fall), .rise(cnv_rise_unused));
    ad7606x_edge_det u_rd  (.clk(sys_clk), .rst(rst), .din(rd_n),    .fall(rd_fall),  .rise(rd_rise));
    ad7606x_edge_det u_wr  (.clk(sys_clk), .rst(rst), .din(wr_n),    .fall(wr_fall_unused), .rise(wr_rise));

    assign rd_take   = rd_fall & ~cs_n;
    assign rd_done   = rd_rise & ~cs_n;
    assign last_word = (ptr + 5'd1) >= num_w;
    assign word      = (ptr < num_ch) ? {ptr[3:0], conv_cnt} : (STATUS_WORD | {11'd0, num_ch});

    always_comb begin
        state_next = state;
        start_conv = 1'b0;
        conv_done  = 1'b0;
        ovr_next   = 1'b0;
        case (state)
            IDLE: begin
                if (cnv_fall) begin
                    state_next = CONV;
                    start_conv = 1'b1;
                end
            end
            CONV: begin
                if (busy_cnt == 16'd0) begin
                    state_next = READY;
                    conv_done  = 1'b1;
                end
                if (cnv_fall) ovr_next = 1'b1;
            end
            READY: begin
                // A new conversion start abandons the readout and beats any read edge.
                if (cnv_fall) begin
                    ovr_next   = 1'b1;
                    start_conv = 1'b1;
                    state_next = CONV;
                end else if (rd_done && last_word) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            busy         <= 1'b0;
            first_data   <= 1'b0;
            db_o         <= 16'd0;
            db_t         <= 1'b1;
            reg_wr_valid <= 1'b0;
            reg_wr_data  <= 16'd0;
            overrun      <= 1'b0;
            busy_cnt     <= 16'd0;
            conv_cnt     <= 12'd0;
            ptr          <= 5'd0;
            num_w        <= num_words(DEV_CONFIG, 2'd0);
            num_ch       <= num_words(DEV_CONFIG, 2'd0);
        end else begin
            overrun      <= ovr_next;
            reg_wr_valid <= 1'b0;

            if (start_conv) begin
                busy     <= 1'b1;
                busy_cnt <= BUSY_LOAD;
            end else if (state == CONV) begin
                if (conv_done) begin
                    busy     <= 1'b0;
                    conv_cnt <= conv_cnt + 12'd1;
                    ptr      <= 5'd0;
                    num_w    <= num_words(DEV_CONFIG, adc_config_mode);
                    num_ch   <= num_words(DEV_CONFIG, {adc_config_mode[1], 1'b0});
                end else begin
                    busy_cnt <= busy_cnt - 16'd1;
                end
            end

            if (state == READY) begin
                if (start_conv) begin
                    ptr        <= 5'd0;
                    db_t       <= 1'b1;
                    first_data <= 1'b0;
                end else if (rd_take) begin
                    db_o       <= word;
                    db_t       <= 1'b0;
                    first_data <= (ptr == 5'd0);
                end else if (rd_done) begin
                    db_t       <= 1'b1;
                    first_data <= 1'b0;
                    ptr        <= ptr + 5'd1;
                end
            end else begin
                // Reads outside READY see an empty bus and leave the pointer alone.
                if (rd_take) begin
                    db_o       <= 16'd0;
                    db_t       <= 1'b0;
                    first_data <= 1'b0;
                end else if (rd_done) begin
                    db_t       <= 1'b1;
                    first_data <= 1'b0;
                end
            end

            if (cs_n) begin
                db_t       <= 1'b1;
                first_data <= 1'b0;
            end

            if (wr_rise && !cs_n && db_t) begin
                reg_wr_data  <= db_i;
                reg_wr_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ad7606x_pif_responder.sv
// Bench for ad7606x_pif_responder: a 16-channel and an 8-channel instance, with expected
// read words queued at each conversion start and popped as the host reads them back.
module tb_ad7606x_pif_responder;
    import ad7606x_pif_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic        cnvst_n = 1'b1, cs_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
    logic [15:0] db_i = 16'd0;
    int          sel = 0;

    logic        c0, s0, r0, c1, s1, r1;
    logic        busy0, fd0, dbt0, wv0, ov0, busy1, fd1, dbt1, wv1, ov1;
    logic [15:0] dbo0, wd0, dbo1, wd1;
    logic        busy_v, fd_v, dbt_v, wv_v, ov_v;
    logic [15:0] dbo_v, wd_v;

    assign c0 = (sel == 0) ? cnvst_n : 1'b1;
    assign s0 = (sel == 0) ? cs_n    : 1'b1;
    assign r0 = (sel == 0) ? rd_n    : 1'b1;
    assign c1 = (sel == 1) ? cnvst_n : 1'b1;
    assign s1 = (sel == 1) ? cs_n    : 1'b1;
    assign r1 = (sel == 1) ? rd_n    : 1'b1;

    assign busy_v = (sel == 0) ? busy0 : busy1;
    assign fd_v   = (sel == 0) ? fd0   : fd1;
    assign dbt_v  = (sel == 0) ? dbt0  : dbt1;
    assign wv_v   = (sel == 0) ? wv0   : wv1;
    assign ov_v   = (sel == 0) ? ov0   : ov1;
    assign dbo_v  = (sel == 0) ? dbo0  : dbo1;
    assign wd_v   = (sel == 0) ? wd0   : wd1;

    ad7606x_pif_responder #(.DEV_CONFIG(3), .BUSY_CYCLES(10), .STATUS_WORD(16'h5A00)) dut (
        .sys_clk(clk), .rst(rst), .adc_config_mode(mode), .cnvst_n(c0), .cs_n(s0), .rd_n(r0),
        .wr_n(wr_n), .db_i(db_i), .busy(busy0), .first_data(fd0), .db_o(dbo0), .db_t(dbt0),
        .reg_wr_valid(wv0), .reg_wr_data(wd0), .overrun(ov0));

    ad7606x_pif_responder #(.DEV_CONFIG(0), .BUSY_CYCLES(10), .STATUS_WORD(16'h5A00)) dut8 (
        .sys_clk(clk), .rst(rst), .adc_config_mode(mode), .cnvst_n(c1), .cs_n(s1), .rd_n(r1),
        .wr_n(wr_n), .db_i(db_i), .busy(busy1), .first_data(fd1), .db_o(dbo1), .db_t(dbt1),
        .reg_wr_valid(wv1), .reg_wr_data(wd1), .overrun(ov1));

    logic [15:0] exp_q[$];
    int          model_cnt[2];
    int          rd_idx = 0;
    int          tests_run = 0;
    int          failed = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic state_t cur_state();
        return (sel == 0) ? dut.state : dut8.state;
    endfunction

    task automatic check_state(input string name, input state_t exp);
        tests_run++;
        if (cur_state() !== exp) begin
            failed++;
            $display("FAIL %s: state got %0d expected %0d", name, cur_state(), exp);
        end
    endtask

    // Start a conversion, queue its words, and count busy/overrun cycles until busy drops.
    task automatic do_conv(input int inject_at, output int busy_n, output int ovr_n);
        int          dev;
        logic [4:0]  nw, nch;
        logic [15:0] w;
        dev = (sel == 0) ? 3 : 0;
        model_cnt[sel] = (model_cnt[sel] + 1) % 4096;
        nw  = num_words(dev, mode);
        nch = num_words(dev, {mode[1], 1'b0});
        exp_q.delete();
        rd_idx = 0;
        for (int k = 0; k < int'(nw); k++) begin
            if (k < int'(nch)) w = {4'(k), 12'(model_cnt[sel])};
            else               w = 16'h5A00 | {11'd0, nch};
            exp_q.push_back(w);
        end
        cnvst_n = 1'b0;
        step();
        cnvst_n = 1'b1;
        busy_n = 0;
        ovr_n  = 0;
        while (busy_v && busy_n < 100) begin
            busy_n++;
            if (ov_v) ovr_n++;
            cnvst_n = (busy_n == inject_at) ? 1'b0 : 1'b1;
            step();
        end
        cnvst_n = 1'b1;
        if (ov_v) ovr_n++;
    endtask

    task automatic conv_check(input string name, input int inject_at, input int exp_ovr);
        int b, o;
        do_conv(inject_at, b, o);
        tests_run++;
        if (b != 10 || o != exp_ovr) begin
            failed++;
            $display("FAIL %s: busy cycles %0d overruns %0d, expected 10 and %0d", name, b, o, exp_ovr);
        end
        check_state({name, "_ready"}, READY);
    endtask

    task automatic read_check(input string name);
        logic [15:0] exp;
        logic        exp_fd;
        tests_run++;
        if (exp_q.size() == 0) begin
            failed++;
            $display("FAIL %s: no expected word queued", name);
            return;
        end
        exp    = exp_q.pop_front();
        exp_fd = (rd_idx == 0);
        rd_idx++;
        cs_n = 1'b0;
        rd_n = 1'b0;
        step();
        if (dbo_v !== exp || dbt_v !== 1'b0 || fd_v !== exp_fd) begin
            failed++;
            $display("FAIL %s[%0d]: db_o=%h db_t=%b first=%b, expected %h 0 %b",
                     name, rd_idx - 1, dbo_v, dbt_v, fd_v, exp, exp_fd);
        end
        rd_n = 1'b1;
        step();
        tests_run++;
        if (dbt_v !== 1'b1 || fd_v !== 1'b0) begin
            failed++;
            $display("FAIL %s_release: db_t=%b first=%b, expected 1 0", name, dbt_v, fd_v);
        end
        cs_n = 1'b1;
    endtask

    task automatic drain(input string name);
        while (exp_q.size() > 0) read_check(name);
        check_state({name, "_idle"}, IDLE);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        tests_run++;
        if (busy0 !== 1'b0 || fd0 !== 1'b0 || dbo0 !== 16'd0 || dbt0 !== 1'b1 ||
            wv0 !== 1'b0 || wd0 !== 16'd0 || ov0 !== 1'b0) begin
            failed++;
            $display("FAIL reset16: busy=%b fd=%b db_o=%h db_t=%b wv=%b wd=%h ov=%b, expected 0 0 0000 1 0 0000 0",
                     busy0, fd0, dbo0, dbt0, wv0, wd0, ov0);
        end
        tests_run++;
        if (busy1 !== 1'b0 || dbt1 !== 1'b1 || ov1 !== 1'b0) begin
            failed++;
            $display("FAIL reset8: busy=%b db_t=%b ov=%b, expected 0 1 0", busy1, dbt1, ov1);
        end
        check_state("reset_state", IDLE);
        rst = 1'b0;
        step();
    endtask

    task automatic test_conversion();
        sel = 0; mode = 2'd0;
        conv_check("conv16", -1, 0);
        drain("read16");
    endtask

    task automatic test_status();
        sel = 0; mode = 2'd1;
        conv_check("conv16s", -1, 0);
        drain("read16s");
        mode = 2'd0;
        conv_check("conv16b", -1, 0);
        drain("read16b");
    endtask

    task automatic test_8ch();
        sel = 1; mode = 2'd0;
        conv_check("conv8", -1, 0);
        drain("read8");
        mode = 2'd1;
        conv_check("conv8s", -1, 0);
        drain("read8s");
        mode = 2'd2;
        conv_check("conv8d", -1, 0);
        drain("read8d");
        sel = 0; mode = 2'd0;
        step();
    endtask

    task automatic test_overrun();
        sel = 0; mode = 2'd0;
        conv_check("ovr_conv", 4, 1);
        for (int i = 0; i < 3; i++) read_check("ovr_pre");
        conv_check("ovr_ready", -1, 1);
        drain("ovr_post");
    endtask

    task automatic test_idle_read();
        cs_n = 1'b0; rd_n = 1'b0;
        step();
        tests_run++;
        if (dbo_v !== 16'd0 || dbt_v !== 1'b0 || fd_v !== 1'b0) begin
            failed++;
            $display("FAIL idle_read: db_o=%h db_t=%b first=%b, expected 0000 0 0", dbo_v, dbt_v, fd_v);
        end
        rd_n = 1'b1;
        step();
        tests_run++;
        if (dbt_v !== 1'b1) begin
            failed++;
            $display("FAIL idle_release: db_t=%b expected 1", dbt_v);
        end
        cs_n = 1'b1;
        check_state("idle_read_state", IDLE);
    endtask

    task automatic test_write();
        int          pulses;
        logic [15:0] got;
        pulses = 0;
        got = 16'd0;
        cs_n = 1'b0; db_i = 16'h1234; wr_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            if (wv_v) pulses++;
        end
        wr_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (wv_v) begin
                pulses++;
                got = wd_v;
            end
        end
        cs_n = 1'b1;
        db_i = 16'd0;
        tests_run++;
        if (pulses != 1 || got !== 16'h1234) begin
            failed++;
            $display("FAIL write: pulses=%0d data=%h, expected 1 1234", pulses, got);
        end
        tests_run++;
        if (wd_v !== 16'h1234) begin
            failed++;
            $display("FAIL write_hold: reg_wr_data=%h expected 1234", wd_v);
        end
    endtask

    task automatic test_cs_ignore();
        int bad;
        bad = 0;
        conv_check("csi_conv", -1, 0);
        read_check("csi_pre");
        read_check("csi_pre");
        cs_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rd_n = 1'b0;
            step();
            if (dbt_v !== 1'b1) bad++;
            rd_n = 1'b1;
            step();
            if (dbt_v !== 1'b1) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            failed++;
            $display("FAIL cs_ignore: db_t low on %0d samples, expected 0", bad);
        end
        drain("csi_post");
    endtask

    task automatic test_reset_midread();
        conv_check("rst_conv", -1, 0);
        for (int i = 0; i < 5; i++) read_check("rst_pre");
        cs_n = 1'b0; rd_n = 1'b0;
        step();
        rst = 1'b1;
        step();
        tests_run++;
        if (busy0 !== 1'b0 || fd0 !== 1'b0 || dbo0 !== 16'd0 || dbt0 !== 1'b1 ||
            wv0 !== 1'b0 || wd0 !== 16'd0 || ov0 !== 1'b0) begin
            failed++;
            $display("FAIL rst_mid: busy=%b fd=%b db_o=%h db_t=%b wv=%b wd=%h ov=%b, expected 0 0 0000 1 0 0000 0",
                     busy0, fd0, dbo0, dbt0, wv0, wd0, ov0);
        end
        check_state("rst_mid_state", IDLE);
        tests_run++;
        if (dut.ptr !== 5'd0) begin
            failed++;
            $display("FAIL rst_mid_ptr: ptr=%0d expected 0", dut.ptr);
        end
        rst = 1'b0; rd_n = 1'b1; cs_n = 1'b1;
        model_cnt[0] = 0;
        model_cnt[1] = 0;
        exp_q.delete();
        step();
        step();
        conv_check("rst_fresh", -1, 0);
        drain("rst_read");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, failed + 1);
        $fatal(1, "time limit");
    end

    initial begin
        model_cnt[0] = 0;
        model_cnt[1] = 0;
        test_reset();
        test_conversion();
        test_status();
        test_8ch();
        test_overrun();
        test_idle_read();
        test_write();
        test_cs_ignore();
        test_reset_midread();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
